// File: rtl/sm_stepper_ctrl_if.sv
// Command/status bundle between a motion master and the stepper controller.
interface sm_stepper_ctrl_if #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 16
);
    logic             EN;
    logic [1:0]       MODE;
    logic             DIR;
    logic [DIV_W-1:0] DIV;
    logic [CNT_W-1:0] STEPS;
    logic             START;
    logic             STOP;
    logic             A1;
    logic             B1;
    logic             A2;
    logic             B2;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] STEPS_LEFT;
    logic [2:0]       PHASE;

    modport master (
        output EN, MODE, DIR, DIV, STEPS, START, STOP,
        input  A1, B1, A2, B2, BUSY, DONE, STEPS_LEFT, PHASE
    );

    modport slave (
        input  EN, MODE, DIR, DIV, STEPS, START, STOP,
        output A1, B1, A2, B2, BUSY, DONE, STEPS_LEFT, PHASE
    );
endinterface

// File: rtl/sm_stepper_ctrl.sv
// Two-phase bipolar stepper sequencer: wave/full/half stepping with a
// programmable step period, step count, pause (EN) and abort (STOP).
module sm_stepper_ctrl #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    sm_stepper_ctrl_if.slave bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_WAVE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b10;

    state_t           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       coils_q, coils_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             want_odd;
    logic             single_step;
    logic [2:0]       step_mag;
    logic [2:0]       phase_step;

    // {A1,B1,A2,B2} for each phase index
    function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    // Wave sits on even indices, full on odd; a misaligned index takes one
    // single step to land on the right parity, after which steps are double.
    assign want_odd    = (mode_q != MODE_WAVE);
    assign single_step = (mode_q == MODE_HALF) || (phase_q[0] != want_odd);
    assign step_mag    = single_step ? 3'd1 : 3'd2;
    assign phase_step  = dir_q ? (phase_q + step_mag) : (phase_q - step_mag);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            phase_q <= 3'd0;
            presc_q <= '0;
            steps_q <= '0;
            mode_q  <= 2'b00;
            dir_q   <= 1'b0;
            div_q   <= '0;
            coils_q <= 4'b0000;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            presc_q <= presc_d;
            steps_q <= steps_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            div_q   <= div_d;
            coils_q <= coils_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        presc_d = presc_q;
        steps_d = steps_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        div_d   = div_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    if (bus.STEPS != '0) begin
                        state_d = S_RUN;
                        mode_d  = bus.MODE;
                        dir_d   = bus.DIR;
                        div_d   = bus.DIV;
                        steps_d = bus.STEPS;
                        presc_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // STOP wins over a step due in the same cycle
                if (bus.STOP) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (bus.EN) begin
                    if (presc_q == div_q) begin
                        presc_d = '0;
                        phase_d = phase_step;
                        steps_d = steps_q - CNT_W'(1);
                        if (steps_q == CNT_W'(1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d == S_RUN);
        coils_d = bus.EN ? coil_pattern(phase_d) : 4'b0000;
    end

    assign bus.A1         = coils_q[3];
    assign bus.B1         = coils_q[2];
    assign bus.A2         = coils_q[1];
    assign bus.B2         = coils_q[0];
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.STEPS_LEFT = steps_q;
    assign bus.PHASE      = phase_q;

endmodule
